dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates the single-port data memory between the core's load/store path and a host port used for preloading and inspecting memory, one access per cycle. Core loses arbitration -> core_stall asserts so the PC and register write hold. Tracks one-cycle synchronous read latency and returns each read to the requester that issued it. Includes a host starvation guard and a bounded host lock (burst) mode.

Parameters:
AW, 8, address width (data memory address bus)
DW, 8, data width
STARVE_MAX, 4, consecutive lost host cycles before the host is forced to win
BURST_MAX, 16, max consecutive cycles the host may hold the memory in lock mode

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
core_req  in  1  core requests access this cycle
core_we  in  1  1=store, 0=load
core_addr  in  AW  core address
core_wdata  in  DW  core store data
core_stall  out  1  core request not issued this cycle; core must hold request and state
core_rvalid  out  1  core_rdata valid (cycle after core read issued)
core_rdata  out  DW  core read data
host_req  in  1  host requests access
host_we  in  1  1=write, 0=read
host_lock  in  1  host requests exclusive hold (burst)
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_gnt  out  1  host request issued this cycle
host_rvalid  out  1  host_rdata valid
host_rdata  out  DW  host read data
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid one cycle after read address presented
locked  out  1  FSM in S_LOCK

Behaviour:
- States: S_ARB, S_LOCK. Reset -> S_ARB, starve_cnt=0, burst_cnt=0, rd_owner=none; core_rvalid=host_rvalid=locked=0.
- Issue decision is combinational from current state/counters/inputs; at most one issue per cycle.
- S_ARB winner: host if host_req && (!core_req || starve_cnt==STARVE_MAX); else core if core_req; else none.
- S_LOCK winner: host if host_req; else none. Core never issues in S_LOCK.
- core_stall = core_req && winner!=core. host_gnt = (winner==host). No request -> core_stall=0.
- mem_we/addr/wdata driven from winner; mem_we=0 when no winner (mem_addr don't-care).
- starve_cnt: +1 (saturate at STARVE_MAX) when host_req && !host_gnt; clears when host_gnt or !host_req.
- S_ARB -> S_LOCK when host_gnt && host_lock; burst_cnt <= 1.
- In S_LOCK: burst_cnt +1 per cycle. Exit to S_ARB when !host_lock, or burst_cnt==BURST_MAX (forced); forced exit also clears starve_cnt so core wins the next contested cycle.
- Read return: registered rd_owner records who issued a read (we=0); next cycle the matching *_rvalid=1 for exactly one cycle; core_rdata=host_rdata=mem_rdata (pass-through). Writes produce no rvalid.
- Back-to-back reads by alternating owners: each rvalid tracks its own issue cycle; no loss.
- Store by core: takes effect in issue cycle (same as unarbitrated memory); stalled store is not written.
- Reset asserted mid-operation: pending rvalid dropped, lock released, counters cleared immediately.
- Widths: counters sized ceil(log2(max+1)); no wrap, saturate.

Test Plan:
- Core-only: core read addr 0x10 (mem holds 0x5A), host idle -> core_stall=0, next cycle core_rvalid=1, core_rdata=0x5A; host_rvalid stays 0.
- Contention: core_req and host_req held high -> core wins 4 cycles (core_stall=0, host_gnt=0), 5th cycle host_gnt=1, core_stall=1, then core wins again.
- Host write then core read: host writes 0xC3 to 0x20 while core idle; next cycle core reads 0x20 -> core_rdata=0xC3 one cycle later.
- Lock burst: host_lock=1 with host_req held, core_req held -> locked=1, core_stall=1 for 16 cycles, forced exit, core issues next cycle, host_gnt=0 that cycle.
- Alternating reads: host read 0x01 (0x11) then core read 0x02 (0x22) on consecutive cycles -> host_rvalid with 0x11, then core_rvalid with 0x22, never both.
- Reset during S_LOCK with read outstanding -> locked, host_rvalid, starve/burst counters all 0 immediately; after release core_req issues without stall.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the core load/store path and a
// host port used for preloading and inspecting memory. One access is issued
// per cycle. The core normally wins, but a host that keeps losing is forced
// through after STARVE_MAX lost cycles. The host may also hold the memory
// exclusively (lock mode) for at most BURST_MAX cycles. Reads have one cycle
// of latency and are returned to whichever requester issued them.
//
// Valid/ready handshake (both requesters):
//   A request is presented by holding *_req high with its address, write
//   enable and data stable. It is accepted in the cycle where the grant is
//   seen: for the core that is core_req && !core_stall, for the host that is
//   host_gnt. A request that is not accepted must be held unchanged into the
//   next cycle. A read that is accepted in cycle N returns data in cycle N+1
//   with the matching *_rvalid high for exactly that one cycle. Writes are
//   performed in the cycle they are accepted and produce no rvalid.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_core_req/we/addr/wdata       core request
//   o_core_stall                   core request not issued this cycle
//   o_core_rvalid, o_core_rdata    core read return
//   i_host_req/we/lock/addr/wdata  host request (lock = hold memory)
//   o_host_gnt                     host request issued this cycle
//   o_host_rvalid, o_host_rdata    host read return
//   o_mem_we/addr/wdata            memory command
//   i_mem_rdata                    memory read data (one cycle after address)
//   o_locked                       arbiter is in lock state
//   o_dbg_starve_cnt               host starvation counter
//   o_dbg_burst_cnt                lock burst length counter
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 16,
  localparam int SW        = $clog2(STARVE_MAX + 1),
  localparam int BW        = $clog2(BURST_MAX + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  // core port
  input  logic          i_core_req,
  input  logic          i_core_we,
  input  logic [AW-1:0] i_core_addr,
  input  logic [DW-1:0] i_core_wdata,
  output logic          o_core_stall,
  output logic          o_core_rvalid,
  output logic [DW-1:0] o_core_rdata,
  // host port
  input  logic          i_host_req,
  input  logic          i_host_we,
  input  logic          i_host_lock,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_wdata,
  output logic          o_host_gnt,
  output logic          o_host_rvalid,
  output logic [DW-1:0] o_host_rdata,
  // memory port
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  // status / debug
  output logic          o_locked,
  output logic [SW-1:0] o_dbg_starve_cnt,
  output logic [BW-1:0] o_dbg_burst_cnt
);

  typedef enum logic {
    S_ARB  = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  state_t        r_state;
  logic [SW-1:0] r_starve_cnt;
  logic [BW-1:0] r_burst_cnt;
  logic          r_core_rvalid;
  logic          r_host_rvalid;

  owner_t        w_winner;
  logic          w_host_gnt;
  logic          w_starved;
  logic          w_burst_done;

  assign w_starved    = (r_starve_cnt == SW'(STARVE_MAX));
  assign w_burst_done = (r_burst_cnt == BW'(BURST_MAX));

  // Issue decision for the current cycle.
  always_comb begin
    w_winner = OWN_NONE;
    if (r_state == S_LOCK) begin
      // Core is shut out entirely while the host holds the lock.
      if (i_host_req) w_winner = OWN_HOST;
    end else if (i_host_req && (!i_core_req || w_starved)) begin
      w_winner = OWN_HOST;
    end else if (i_core_req) begin
      w_winner = OWN_CORE;
    end
  end

  assign w_host_gnt   = (w_winner == OWN_HOST);
  assign o_host_gnt   = w_host_gnt;
  assign o_core_stall = i_core_req && (w_winner != OWN_CORE);

  // Memory command mux. Address/data follow the core when idle; they are
  // don't-care then since mem_we is low.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = i_core_addr;
    o_mem_wdata = i_core_wdata;
    case (w_winner)
      OWN_CORE: begin
        o_mem_we    = i_core_we;
        o_mem_addr  = i_core_addr;
        o_mem_wdata = i_core_wdata;
      end
      OWN_HOST: begin
        o_mem_we    = i_host_we;
        o_mem_addr  = i_host_addr;
        o_mem_wdata = i_host_wdata;
      end
      default: ;
    endcase
  end

  // State, counters and read-return tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_ARB;
      r_starve_cnt  <= '0;
      r_burst_cnt   <= '0;
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
    end else begin
      // Each read marks its own owner for the following cycle only, so
      // back-to-back reads from different owners never collide.
      r_core_rvalid <= (w_winner == OWN_CORE) && !i_core_we;
      r_host_rvalid <= (w_winner == OWN_HOST) && !i_host_we;

      if (i_host_req && !w_host_gnt) begin
        if (!w_starved) r_starve_cnt <= r_starve_cnt + SW'(1);
      end else begin
        r_starve_cnt <= '0;
      end

      case (r_state)
        S_ARB: begin
          if (w_host_gnt && i_host_lock) begin
            r_state     <= S_LOCK;
            r_burst_cnt <= BW'(1);
          end
        end
        S_LOCK: begin
          if (!i_host_lock || w_burst_done) begin
            r_state     <= S_ARB;
            r_burst_cnt <= '0;
            // A forced exit hands the next contested cycle to the core.
            if (w_burst_done) r_starve_cnt <= '0;
          end else begin
            r_burst_cnt <= r_burst_cnt + BW'(1);
          end
        end
        default: r_state <= S_ARB;
      endcase
    end
  end

  assign o_core_rvalid    = r_core_rvalid;
  assign o_host_rvalid    = r_host_rvalid;
  assign o_core_rdata     = i_mem_rdata;
  assign o_host_rdata     = i_mem_rdata;
  assign o_locked         = (r_state == S_LOCK);
  assign o_dbg_starve_cnt = r_starve_cnt;
  assign o_dbg_burst_cnt  = r_burst_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SW = 3;
  localparam int BW = 5;

  logic          clk;
  logic          rst_n;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_stall, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          locked;
  logic [SW-1:0] dbg_starve;
  logic [BW-1:0] dbg_burst;

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4), .BURST_MAX(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
    .i_core_wdata(core_wdata), .o_core_stall(core_stall),
    .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_lock(host_lock),
    .i_host_addr(host_addr), .i_host_wdata(host_wdata), .o_host_gnt(host_gnt),
    .o_host_rvalid(host_rvalid), .o_host_rdata(host_rdata),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_locked(locked), .o_dbg_starve_cnt(dbg_starve), .o_dbg_burst_cnt(dbg_burst)
  );

  // synchronous-read memory model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_core(input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    core_req = req; core_we = we; core_addr = addr; core_wdata = wd;
  endtask

  task automatic drive_host(input logic req, input logic we, input logic lock,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    host_req = req; host_we = we; host_lock = lock; host_addr = addr; host_wdata = wd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[8'h10] = 8'h5A;
    mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22;
    mem_rdata = '0;
    rst_n = 1'b0;
    drive_core(0, 0, 8'h00, 8'h00);
    drive_host(0, 0, 0, 8'h00, 8'h00);

    // reset state
    next_cycle();
    next_cycle();
    settle();
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_core_rvalid", {31'd0, core_rvalid}, 32'd0);
    chk("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rst_starve", {29'd0, dbg_starve}, 32'd0);
    chk("rst_burst", {27'd0, dbg_burst}, 32'd0);
    chk("rst_stall", {31'd0, core_stall}, 32'd0);
    chk("rst_gnt", {31'd0, host_gnt}, 32'd0);

    // core-only read of 0x10
    next_cycle();
    rst_n = 1'b1;
    drive_core(1, 0, 8'h10, 8'h00);
    settle();
    chk("c_only_stall", {31'd0, core_stall}, 32'd0);
    chk("c_only_mem_we", {31'd0, mem_we}, 32'd0);
    chk("c_only_mem_addr", {24'd0, mem_addr}, 32'h10);
    next_cycle();
    drive_core(0, 0, 8'h00, 8'h00);
    settle();
    chk("c_only_rvalid", {31'd0, core_rvalid}, 32'd1);
    chk("c_only_rdata", {24'd0, core_rdata}, 32'h5A);
    chk("c_only_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    next_cycle();
    settle();
    chk("c_only_rvalid_drop", {31'd0, core_rvalid}, 32'd0);

    // contention: core wins 4, host wins 5th, core again
    next_cycle();
    drive_core(1, 0, 8'h30, 8'h00);
    drive_host(1, 0, 0, 8'h31, 8'h00);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("cont_core_stall%0d", i), {31'd0, core_stall}, 32'd0);
      chk($sformatf("cont_host_gnt%0d", i), {31'd0, host_gnt}, 32'd0);
      next_cycle();
    end
    settle();
    chk("cont5_stall", {31'd0, core_stall}, 32'd1);
    chk("cont5_gnt", {31'd0, host_gnt}, 32'd1);
    chk("cont5_mem_addr", {24'd0, mem_addr}, 32'h31);
    next_cycle();
    settle();
    chk("cont6_stall", {31'd0, core_stall}, 32'd0);
    chk("cont6_gnt", {31'd0, host_gnt}, 32'd0);
    chk("cont6_host_rvalid", {31'd0, host_rvalid}, 32'd1);
    chk("cont6_core_rvalid", {31'd0, core_rvalid}, 32'd0);
    next_cycle();
    drive_core(0, 0, 8'h00, 8'h00);
    drive_host(0, 0, 0, 8'h00, 8'h00);

    // host write 0xC3 to 0x20, then core reads it back
    next_cycle();
    drive_host(1, 1, 0, 8'h20, 8'hC3);
    settle();
    chk("hw_gnt", {31'd0, host_gnt}, 32'd1);
    chk("hw_mem_we", {31'd0, mem_we}, 32'd1);
    chk("hw_mem_addr", {24'd0, mem_addr}, 32'h20);
    chk("hw_mem_wdata", {24'd0, mem_wdata}, 32'hC3);
    next_cycle();
    drive_host(0, 0, 0, 8'h00, 8'h00);
    drive_core(1, 0, 8'h20, 8'h00);
    settle();
    chk("hw_no_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("cr_stall", {31'd0, core_stall}, 32'd0);
    next_cycle();
    drive_core(0, 0, 8'h00, 8'h00);
    settle();
    chk("cr_rvalid", {31'd0, core_rvalid}, 32'd1);
    chk("cr_rdata", {24'd0, core_rdata}, 32'hC3);

    // uncontested core store
    next_cycle();
    drive_core(1, 1, 8'h40, 8'h77);
    settle();
    chk("cs_mem_we", {31'd0, mem_we}, 32'd1);
    chk("cs_mem_wdata", {24'd0, mem_wdata}, 32'h77);
    next_cycle();
    drive_core(0, 0, 8'h00, 8'h00);
    settle();
    chk("cs_no_rvalid", {31'd0, core_rvalid}, 32'd0);

    // lock burst with core contending
    next_cycle();
    drive_core(1, 0, 8'h10, 8'h00);
    drive_host(1, 0, 1, 8'h01, 8'h00);
    for (int i = 0; i < 4; i++) next_cycle();
    settle();
    chk("lk_entry_gnt", {31'd0, host_gnt}, 32'd1);
    chk("lk_entry_locked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      settle();
      chk($sformatf("lk_locked%0d", i), {31'd0, locked}, 32'd1);
      chk($sformatf("lk_stall%0d", i), {31'd0, core_stall}, 32'd1);
      chk($sformatf("lk_burst%0d", i), {27'd0, dbg_burst}, i + 1);
    end
    next_cycle();
    settle();
    chk("lk_exit_locked", {31'd0, locked}, 32'd0);
    chk("lk_exit_stall", {31'd0, core_stall}, 32'd0);
    chk("lk_exit_gnt", {31'd0, host_gnt}, 32'd0);
    next_cycle();
    drive_core(0, 0, 8'h00, 8'h00);
    drive_host(0, 0, 0, 8'h00, 8'h00);
    next_cycle();

    // alternating reads: host 0x01 then core 0x02
    next_cycle();
    drive_host(1, 0, 0, 8'h01, 8'h00);
    settle();
    chk("alt_host_gnt", {31'd0, host_gnt}, 32'd1);
    next_cycle();
    drive_host(0, 0, 0, 8'h00, 8'h00);
    drive_core(1, 0, 8'h02, 8'h00);
    settle();
    chk("alt_host_rvalid", {31'd0, host_rvalid}, 32'd1);
    chk("alt_host_rdata", {24'd0, host_rdata}, 32'h11);
    chk("alt_core_rvalid_lo", {31'd0, core_rvalid}, 32'd0);
    next_cycle();
    drive_core(0, 0, 8'h00, 8'h00);
    settle();
    chk("alt_core_rvalid", {31'd0, core_rvalid}, 32'd1);
    chk("alt_core_rdata", {24'd0, core_rdata}, 32'h22);
    chk("alt_host_rvalid_lo", {31'd0, host_rvalid}, 32'd0);

    // reset while locked with a host read outstanding
    next_cycle();
    drive_host(1, 0, 1, 8'h01, 8'h00);
    next_cycle();
    settle();
    chk("rl_locked", {31'd0, locked}, 32'd1);
    chk("rl_host_rvalid", {31'd0, host_rvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rl_rst_locked", {31'd0, locked}, 32'd0);
    chk("rl_rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rl_rst_starve", {29'd0, dbg_starve}, 32'd0);
    chk("rl_rst_burst", {27'd0, dbg_burst}, 32'd0);
    next_cycle();
    drive_host(0, 0, 0, 8'h00, 8'h00);
    rst_n = 1'b1;
    drive_core(1, 0, 8'h10, 8'h00);
    settle();
    chk("rl_post_stall", {31'd0, core_stall}, 32'd0);
    next_cycle();
    drive_core(0, 0, 8'h00, 8'h00);
    settle();
    chk("rl_post_rvalid", {31'd0, core_rvalid}, 32'd1);
    chk("rl_post_rdata", {24'd0, core_rdata}, 32'h5A);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
